// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
//
// Oversampled UART receive front-end. It recovers serial frames from rxd_i and
// presents one parallel word per frame. Its output feeds a receive FIFO write
// port directly, and busy_o goes back to the baud generator.
//
// Each bit is sampled three times around mid-bit (ticks M-1, M and M+1 of the
// bit, where M = OverSampleRate/2). A majority vote of those samples decides
// the bit. This rejects single-tick glitches. A start bit that does not vote
// low is treated as a false start. A stop bit that votes low raises a framing
// error, and the receiver then waits for the line to go idle again.
//
// Optional feature (compile-time macro UART_RX_PARITY_EN):
//   When defined, a parity bit is expected between the last data bit and the
//   stop bit. The parity_odd_i and parity_err_o ports are added. The word is
//   still delivered on a parity failure; parity_err_o pulses alongside dv_o.
//
// Parameters
//   DataWidth       data bits per frame, LSB first (5..9)
//   OverSampleRate  tick_i pulses per bit period (>= 4)
//   SyncStages      flops in the rxd_i synchroniser (>= 2)
//
// Ports
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   tick_i        oversample strobe, one clk_i cycle wide
//   rxd_i         asynchronous serial input, idle high
//   parity_odd_i  (UART_RX_PARITY_EN) 1: odd parity, 0: even parity
//   parity_err_o  (UART_RX_PARITY_EN) one-cycle pulse with dv_o on parity fail
//   dv_o          one-cycle pulse: data_o holds a freshly received word
//   data_o        last received word
//   frame_err_o   one-cycle pulse: stop bit sampled low
//   busy_o        high whenever the receiver is not idle

module uart_rx_deserializer #(
  parameter int unsigned DataWidth      = 8,
  parameter int unsigned OverSampleRate = 16,
  parameter int unsigned SyncStages     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tick_i,
  input  logic                 rxd_i,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd_i,
  output logic                 parity_err_o,
`endif
  output logic                 dv_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int unsigned TickW = $clog2(OverSampleRate);
  localparam int unsigned BitW  = $clog2(DataWidth);
  localparam int unsigned Mid   = OverSampleRate / 2;

  localparam logic [TickW-1:0] SampEarly = TickW'(Mid - 1);
  localparam logic [TickW-1:0] SampMid   = TickW'(Mid);
  localparam logic [TickW-1:0] Decide    = TickW'(Mid + 1);
  localparam logic [TickW-1:0] TickLast  = TickW'(OverSampleRate - 1);
  localparam logic [BitW-1:0]  BitLast   = BitW'(DataWidth - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser. Resets to the idle level so that reset release does
  // not look like a start edge.
  // ---------------------------------------------------------------------------
  logic [SyncStages-1:0] sync_q;
  logic                  rxs;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], rxd_i};
    end
  end

  assign rxs = sync_q[SyncStages-1];

  // ---------------------------------------------------------------------------
  // Bit decision: majority of the two stored samples and the live sample
  // taken at the decision tick.
  // ---------------------------------------------------------------------------
  state_e                 state_q;
  logic [TickW-1:0]       tick_cnt_q;
  logic [BitW-1:0]        bit_cnt_q;
  logic [1:0]             samp_q;
  logic [DataWidth-1:0]   shift_q;
  logic                   bitval;
  logic                   at_decide;
  logic                   at_last;

  assign bitval    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
  assign at_decide = (tick_cnt_q == Decide);
  assign at_last   = (tick_cnt_q == TickLast);

`ifdef UART_RX_PARITY_EN
  logic parity_bit_q;
  logic parity_bad;

  // Count of ones over data and parity bit must be odd for odd parity.
  assign parity_bad = ((^shift_q) ^ parity_bit_q) != parity_odd_i;
`endif

  // ---------------------------------------------------------------------------
  // Receive FSM with registered outputs. Everything except the output pulse
  // clearing advances only on tick_i.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      samp_q       <= '0;
      shift_q      <= '0;
      data_o       <= '0;
      dv_o         <= 1'b0;
      frame_err_o  <= 1'b0;
      busy_o       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      dv_o        <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      if (tick_i) begin
        if (tick_cnt_q == SampEarly) begin
          samp_q[0] <= rxs;
        end
        if (tick_cnt_q == SampMid) begin
          samp_q[1] <= rxs;
        end

        unique case (state_q)
          StIdle: begin
            if (!rxs) begin
              state_q    <= StStart;
              tick_cnt_q <= '0;
              busy_o     <= 1'b1;
            end
          end

          StStart: begin
            if (at_decide && bitval) begin
              // Line came back high before mid start bit: noise, not a frame.
              state_q    <= StIdle;
              tick_cnt_q <= '0;
              busy_o     <= 1'b0;
            end else if (at_last) begin
              state_q    <= StData;
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end

          StData: begin
            if (at_decide) begin
              shift_q[bit_cnt_q] <= bitval;
            end
            if (at_last) begin
              tick_cnt_q <= '0;
              if (bit_cnt_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                state_q <= StParity;
`else
                state_q <= StStop;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end

`ifdef UART_RX_PARITY_EN
          StParity: begin
            if (at_decide) begin
              parity_bit_q <= bitval;
            end
            if (at_last) begin
              state_q    <= StStop;
              tick_cnt_q <= '0;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
`endif

          StStop: begin
            // Leave at mid stop bit so the next start edge is not missed.
            if (at_decide) begin
              tick_cnt_q <= '0;
              if (bitval) begin
                data_o  <= shift_q;
                dv_o    <= 1'b1;
                state_q <= StIdle;
                busy_o  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_o <= parity_bad;
`endif
              end else begin
                frame_err_o <= 1'b1;
                state_q     <= StBreak;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end

          StBreak: begin
            // A line held low must not be re-read as a stream of frames.
            if (rxs) begin
              state_q    <= StIdle;
              tick_cnt_q <= '0;
              busy_o     <= 1'b0;
            end
          end

          default: begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            busy_o     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer (OSR=16, one tick every 4 clk).
// Output events (dv_o / frame_err_o) are checked by a scoreboard monitor that
// pops expected events pushed by the stimulus; cycle-exact timing checks run
// alongside the stimulus.

module tb_uart_rx_deserializer;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       tick_i = 1'b0;
  logic       rxd_i = 1'b1;
  logic       dv_o;
  logic [7:0] data_o;
  logic       frame_err_o;
  logic       busy_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd_i = 1'b0;
  logic       parity_err_o;
`endif

  uart_rx_deserializer #(
    .DataWidth     (8),
    .OverSampleRate(16),
    .SyncStages    (2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .tick_i      (tick_i),
    .rxd_i       (rxd_i),
`ifdef UART_RX_PARITY_EN
    .parity_odd_i(parity_odd_i),
    .parity_err_o(parity_err_o),
`endif
    .dv_o        (dv_o),
    .data_o      (data_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_ph = 0;

  typedef struct {
    logic       ferr;
    logic [7:0] data;
    logic       perr;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  logic [7:0] last_word = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One-clock tick every 4 clocks, driven away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      tick_i  = (tick_ph == 0);
      tick_ph = (tick_ph + 1) % 4;
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (dv_o || frame_err_o) begin
        chk("dv_ferr_exclusive", 32'(dv_o & frame_err_o), 32'd0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got dv=%0b ferr=%0b data=%0h, required no event",
                   dv_o, frame_err_o, data_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("event_is_ferr", 32'(frame_err_o), 32'(mon_e.ferr));
          chk("event_data", 32'(data_o), 32'(mon_e.data));
`ifdef UART_RX_PARITY_EN
          chk("event_parity_err", 32'(parity_err_o), 32'(mon_e.perr));
`endif
        end
      end
    end
  end

  // Lands 1 time unit after the n-th following falling edge.
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Returns 1 unit after the falling edge on which tick_i was raised.
  task automatic align_tick();
    do begin
      @(negedge clk);
      #1;
    end while (!tick_i);
  endtask

  // 64 clk per bit. Optional 4-clk inversion placed so that it lands on the
  // mid sample (tick_cnt = M) of data bit glitch_bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit,
                            input logic use_par, input logic par);
    rxd_i = 1'b0;
    wait_clk(64);
    for (int i = 0; i < 8; i++) begin
      rxd_i = d[i];
      if (i == glitch_bit) begin
        wait_clk(38);
        rxd_i = ~d[i];
        wait_clk(4);
        rxd_i = d[i];
        wait_clk(22);
      end else begin
        wait_clk(64);
      end
    end
    if (use_par) begin
      rxd_i = par;
      wait_clk(64);
    end
    rxd_i = stop;
    wait_clk(64);
  endtask

  task automatic push_ev(input logic ferr, input logic [7:0] data, input logic perr);
    ev_t e;
    e.ferr = ferr;
    e.data = data;
    e.perr = perr;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset state.
    wait_clk(5);
    chk("reset_dv", 32'(dv_o), 32'd0);
    chk("reset_data", 32'(data_o), 32'd0);
    chk("reset_ferr", 32'(frame_err_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
`ifdef UART_RX_PARITY_EN
    chk("reset_perr", 32'(parity_err_o), 32'd0);
`endif
    rst_ni = 1'b1;
    wait_clk(20);

    // Test 1: clean frame 0xA5, with busy and dv timing.
    align_tick();
    push_ev(1'b0, 8'hA5, 1'b0);
    last_word = 8'hA5;
    fork
      send_frame(8'hA5, 1'b1, -1, 1'b0, 1'b0);
      begin
        wait_clk(4);
        chk("t1_busy_before_start", 32'(busy_o), 32'd0);
        wait_clk(1);
        chk("t1_busy_after_start", 32'(busy_o), 32'd1);
        wait_clk(615);
        chk("t1_busy_at_stop", 32'(busy_o), 32'd1);
        chk("t1_dv_before_decision", 32'(dv_o), 32'd0);
        wait_clk(1);
        chk("t1_dv_latency", 32'(dv_o), 32'd1);
        chk("t1_data", 32'(data_o), 32'hA5);
        chk("t1_busy_after_stop", 32'(busy_o), 32'd0);
        chk("t1_ferr", 32'(frame_err_o), 32'd0);
        wait_clk(1);
        chk("t1_dv_one_cycle", 32'(dv_o), 32'd0);
      end
    join
    wait_clk(100);

    // Test 2: 5-tick low pulse is a false start.
    align_tick();
    fork
      begin
        rxd_i = 1'b0;
        wait_clk(20);
        rxd_i = 1'b1;
      end
      begin
        wait_clk(44);
        chk("t2_busy_before_decision", 32'(busy_o), 32'd1);
        wait_clk(1);
        chk("t2_busy_after_decision", 32'(busy_o), 32'd0);
      end
    join
    wait_clk(200);

    // Test 3: 0x3C with low stop bit, line held low for 40 ticks.
    align_tick();
    push_ev(1'b1, last_word, 1'b0);
    fork
      begin
        send_frame(8'h3C, 1'b0, -1, 1'b0, 1'b0);
        wait_clk(160);
        rxd_i = 1'b1;
      end
      begin
        wait_clk(621);
        chk("t3_ferr_pulse", 32'(frame_err_o), 32'd1);
        chk("t3_no_dv", 32'(dv_o), 32'd0);
        wait_clk(179);
        chk("t3_busy_in_break", 32'(busy_o), 32'd1);
        wait_clk(6);
        chk("t3_busy_after_break", 32'(busy_o), 32'd0);
        chk("t3_data_kept", 32'(data_o), 32'hA5);
      end
    join
    wait_clk(200);

    // Test 4: 0x5A with a one-tick glitch on bit 3 at tick_cnt = M.
    align_tick();
    push_ev(1'b0, 8'h5A, 1'b0);
    last_word = 8'h5A;
    send_frame(8'h5A, 1'b1, 3, 1'b0, 1'b0);
    wait_clk(100);
    chk("t4_data", 32'(data_o), 32'h5A);

    // Test 5: reset during data bit 4, then clean frame 0xC3.
    align_tick();
    rxd_i = 1'b0;
    wait_clk(64);
    for (int i = 0; i < 4; i++) begin
      rxd_i = (8'hC3 >> i) & 8'h01;
      wait_clk(64);
    end
    rxd_i = 1'b0;
    wait_clk(20);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_dv", 32'(dv_o), 32'd0);
    chk("t5_rst_data", 32'(data_o), 32'd0);
    chk("t5_rst_ferr", 32'(frame_err_o), 32'd0);
    chk("t5_rst_busy", 32'(busy_o), 32'd0);
    rxd_i = 1'b1;
    last_word = 8'h00;
    wait_clk(3);
    rst_ni = 1'b1;
    wait_clk(100);
    align_tick();
    push_ev(1'b0, 8'hC3, 1'b0);
    last_word = 8'hC3;
    send_frame(8'hC3, 1'b1, -1, 1'b0, 1'b0);
    wait_clk(100);
    chk("t5_data_after_reset", 32'(data_o), 32'hC3);

`ifdef UART_RX_PARITY_EN
    // Test 6: odd parity on 0x01.
    parity_odd_i = 1'b1;
    wait_clk(10);
    align_tick();
    push_ev(1'b0, 8'h01, 1'b0);
    send_frame(8'h01, 1'b1, -1, 1'b1, 1'b0);
    wait_clk(100);
    align_tick();
    push_ev(1'b0, 8'h01, 1'b1);
    send_frame(8'h01, 1'b1, -1, 1'b1, 1'b1);
    wait_clk(100);
    chk("t6_data", 32'(data_o), 32'h01);
`endif

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
